// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline buffers: default field
// widths, the bubble instruction and the entry record passed from IF to ID.
package pipe_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned INSTR_W_DEF = 16;

  // Instruction presented downstream when no real entry is available.
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 16'h0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  addr;
    logic [INSTR_W_DEF-1:0] instr;
  } if_id_entry_t;

endpackage : pipe_pkg

// File: rtl/pipe_ptr_ctrl.sv
// Read/write pointer and occupancy tracker for a power-of-two circular
// buffer. Occupancy is kept as its own counter so that full and empty never
// alias when the pointers are equal. A flush empties the buffer in one edge
// and overrides any push or pop requested on that edge.
module pipe_ptr_ctrl #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic             flush,
  output logic             push,
  output logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  // Qualify requests against current occupancy; flush suppresses both.
  always_comb begin
    full_s  = (count_q == CNT_W'(DEPTH));
    empty_s = (count_q == {CNT_W{1'b0}});
    push_s  = push_req && !full_s  && !flush;
    pop_s   = pop_req  && !empty_s && !flush;
  end

  // Next-state for pointers and occupancy; pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy state, updated on the falling edge like the datapath.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Drive outputs from the registered state and qualified strobes.
  always_comb begin
    push   = push_s;
    pop    = pop_s;
    wr_ptr = wr_ptr_q;
    rd_ptr = rd_ptr_q;
    count  = count_q;
    full   = full_s;
    empty  = empty_s;
  end

endmodule : pipe_ptr_ctrl

// File: rtl/if_id_pipe_buf.sv
// IF/ID pipeline buffer: a DEPTH-entry queue of {addr, instr} pairs with
// valid/ready on both sides, one-edge flush, a NOP bubble when empty and a
// saturating count of edges on which ID stalled a valid head entry.
module if_id_pipe_buf
  import pipe_pkg::*;
#(
  parameter  int unsigned              ADDR_W    = ADDR_W_DEF,
  parameter  int unsigned              INSTR_W   = INSTR_W_DEF,
  parameter  int unsigned              DEPTH     = 2,
  parameter  logic [INSTR_W-1:0]       NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter  int unsigned              CNT_W     = 16,
  localparam int unsigned              PTR_W     = $clog2(DEPTH),
  localparam int unsigned              OCC_W     = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               flush,
  input  logic               clr_stats,
  output logic [OCC_W-1:0]   count,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic             push_s;
  logic             pop_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;
  logic [OCC_W-1:0] count_s;
  logic             full_s;
  logic             empty_s;

  // Storage is deliberately left unreset; empty masking hides stale data.
  logic [ADDR_W-1:0]  mem_addr_q  [DEPTH];
  logic [INSTR_W-1:0] mem_instr_q [DEPTH];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_inc_s;

  pipe_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (in_valid),
    .pop_req  (out_ready),
    .flush    (flush),
    .push     (push_s),
    .pop      (pop_s),
    .wr_ptr   (wr_ptr_s),
    .rd_ptr   (rd_ptr_s),
    .count    (count_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Capture the accepted fetch entry into the tail slot.
  always_ff @(negedge clk) begin
    if (push_s) begin
      mem_addr_q[wr_ptr_s]  <= in_addr;
      mem_instr_q[wr_ptr_s] <= in_instr;
    end
  end

  // Present the head entry, or a bubble with zero address when empty.
  always_comb begin
    in_ready  = !full_s;
    out_valid = !empty_s;
    count     = count_s;
    if (empty_s) begin
      out_addr  = {ADDR_W{1'b0}};
      out_instr = NOP_INSTR;
    end else begin
      out_addr  = mem_addr_q[rd_ptr_s];
      out_instr = mem_instr_q[rd_ptr_s];
    end
  end

  // Stall counter next value: clear wins, otherwise saturating increment.
  always_comb begin
    stall_inc_s = out_valid && !out_ready && !flush;
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (stall_inc_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter state.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Expose the stall counter.
  always_comb begin
    stall_cnt = stall_cnt_q;
  end

endmodule : if_id_pipe_buf

// File: tb/tb_if_id_pipe_buf.sv
// Directed bench for if_id_pipe_buf (DEPTH=2, CNT_W=4). Stimulus pushes the
// entries it expects to see leave the buffer into a queue; a monitor on the
// rising edge pops and compares whenever ID consumes the head.
module tb_if_id_pipe_buf;
  import pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_addr;
  logic [15:0] out_instr;
  logic        flush;
  logic        clr_stats;
  logic [1:0]  count;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  if_id_entry_t exp_q[$];

  if_id_pipe_buf #(
    .ADDR_W    (16),
    .INSTR_W   (16),
    .DEPTH     (2),
    .NOP_INSTR (16'h0000),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_instr (out_instr),
    .flush     (flush),
    .clr_stats (clr_stats),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move to just after the next active (falling) edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] i, input logic expect_out);
    in_valid = v;
    in_addr  = a;
    in_instr = i;
    if (expect_out) exp_q.push_back('{addr: a, instr: i});
  endtask

  // Monitor: a pop happens on the next falling edge when this holds.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h/%0h expected none", out_addr, out_instr);
      end else begin
        if_id_entry_t e;
        e = exp_q.pop_front();
        check("pop_addr", {16'h0000, out_addr}, {16'h0000, e.addr});
        check("pop_instr", {16'h0000, out_instr}, {16'h0000, e.instr});
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = 16'h0000; in_instr = 16'h0000;
    out_ready = 1'b0; flush = 1'b0; clr_stats = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_out_instr", {16'd0, out_instr}, 32'h0000);
    check("idle_count", {30'd0, count}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_stall", {28'd0, stall_cnt}, 32'd0);

    // Single pass
    out_ready = 1'b1;
    drive(1'b1, 16'h0010, 16'h1234, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_instr", {16'd0, out_instr}, 32'h1234);
    check("single_count", {30'd0, count}, 32'd1);
    tick();
    check("single_nop", {16'd0, out_instr}, 32'h0000);
    check("single_empty", {31'd0, out_valid}, 32'd0);

    // Fill and backpressure
    out_ready = 1'b0;
    drive(1'b1, 16'h0010, 16'hA001, 1'b1);
    tick();
    drive(1'b1, 16'h0012, 16'hA002, 1'b1);
    tick();
    check("fill_count", {30'd0, count}, 32'd2);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'h0014, 16'hA003, 1'b0);
    tick();
    check("full_ign_count", {30'd0, count}, 32'd2);
    check("full_head", {16'd0, out_instr}, 32'hA001);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    out_ready = 1'b1;
    tick();
    check("drain1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("drain_count", {30'd0, count}, 32'd0);
    check("drain_stall", {28'd0, stall_cnt}, 32'd2);

    // Simultaneous push/pop at count 1
    out_ready = 1'b0;
    drive(1'b1, 16'h0020, 16'hB001, 1'b1);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 16'h0022, 16'hB002, 1'b1);
    tick();
    check("pp_count", {30'd0, count}, 32'd1);
    check("pp_instr", {16'd0, out_instr}, 32'hB002);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();

    // Wrap-around streaming of 8 entries
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h0100 + 16'(2 * i), 16'hC000 + 16'(i), 1'b1);
      tick();
      check("stream_count", {30'd0, count}, 32'd1);
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();
    check("stream_done", {30'd0, count}, 32'd0);
    check("stream_stall", {28'd0, stall_cnt}, 32'd2);

    // Flush while full
    out_ready = 1'b0;
    drive(1'b1, 16'h0030, 16'hD001, 1'b0);
    tick();
    drive(1'b1, 16'h0032, 16'hD002, 1'b0);
    tick();
    check("pre_flush_count", {30'd0, count}, 32'd2);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 16'h0034, 16'hD003, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("flush_count", {30'd0, count}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_stall", {28'd0, stall_cnt}, 32'd3);
    out_ready = 1'b0;
    tick();
    check("flush_absent", {31'd0, out_valid}, 32'd0);

    // Saturation and clear
    drive(1'b1, 16'h0040, 16'hE001, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (20) tick();
    check("stall_sat", {28'd0, stall_cnt}, 32'd15);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("stall_clr", {28'd0, stall_cnt}, 32'd0);
    tick();
    check("stall_after_clr", {28'd0, stall_cnt}, 32'd1);

    // Mid-operation asynchronous reset
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_count", {30'd0, count}, 32'd0);
    check("mrst_stall", {28'd0, stall_cnt}, 32'd0);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_instr", {16'd0, out_instr}, 32'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 16'h0050, 16'hF001, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("post_rst_count", {30'd0, count}, 32'd1);
    check("post_rst_addr", {16'd0, out_addr}, 32'h0050);
    out_ready = 1'b1;
    tick();
    check("post_rst_drain", {30'd0, count}, 32'd0);
    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_if_id_pipe_buf
